// File: rtl/router_pkg.sv
// ============================================================================
// Module : router_pkg
// Brief  : Shared mesh constants, packet field layout and packet helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int ROWS_DEF    = 4;
    localparam int COLUMS_DEF  = 4;
    localparam int PCK_SZ_DEF  = 40;
    localparam int N_TERMS     = 2*ROWS_DEF + 2*COLUMS_DEF;

    localparam int NXT_MSB     = PCK_SZ_DEF - 1;
    localparam int NXT_LSB     = PCK_SZ_DEF - 8;
    localparam int DST_MSB     = PCK_SZ_DEF - 9;
    localparam int DST_LSB     = PCK_SZ_DEF - 14;
    localparam int MODE_BIT    = PCK_SZ_DEF - 15;
    localparam int PAYLOAD_MSB = PCK_SZ_DEF - 16;

    typedef logic [PCK_SZ_DEF-1:0] pkt_t;

    function automatic int n_terms_of(input int rows, input int cols);
        return 2*rows + 2*cols;
    endfunction

    function automatic logic [5:0] dst_of(input pkt_t p);
        return p[DST_MSB:DST_LSB];
    endfunction

    function automatic pkt_t pkt_form(input logic [5:0] dst, input logic mode,
                                      input logic [PAYLOAD_MSB:0] payload);
        return {8'h00, dst, mode, payload};
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_fwft_fifo.sv
// ============================================================================
// Module : router_fwft_fifo
// Brief  : First-word-fall-through FIFO; head entry is visible on o_data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module router_fwft_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   C_OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   C_OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_occ == C_OCC_FULL);
    assign o_empty = (r_occ == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks it to zero below.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/router_term_source.sv
// ============================================================================
// Module : router_term_source
// Brief  : Terminal packet source: buffers generator requests, drops illegal
//          destinations, counts traffic and watches for a stalled router.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module router_term_source
    import router_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLUMS  = 4,
    parameter int PCK_SZ  = 40,
    parameter int TERM_ID = 0,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_dst,
    input  logic              req_mode,
    input  logic [PCK_SZ-16:0] req_payload,
    output logic [PCK_SZ-1:0] data_out,
    output logic              pndng,
    input  logic              pop,
    output logic [15:0]       tx_count,
    output logic [7:0]        drop_count,
    output logic              stall_err,
    output logic              underflow_err
);

    localparam int              C_N_TERMS  = n_terms_of(ROWS, COLUMS);
    localparam logic [6:0]      C_NT_W     = 7'(C_N_TERMS);
    localparam logic [5:0]      C_TERM_ID  = 6'(TERM_ID);
    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] C_TIMEOUT  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] C_WD_ONE   = WD_W'(1);

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_drop;
    logic              w_pop_ok;
    logic [PCK_SZ-1:0] w_pkt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;

    assign req_ready = !w_full;
    assign pndng     = !w_empty;
    assign w_accept  = req_valid && !w_full;
    assign w_legal   = ({1'b0, req_dst} < C_NT_W) && (req_dst != C_TERM_ID);
    assign w_push    = w_accept && w_legal;
    assign w_drop    = w_accept && !w_legal;
    assign w_pop_ok  = pop && !w_empty;
    assign w_pkt     = {8'h00, req_dst, req_mode, req_payload};

    router_fwft_fifo #(
        .WIDTH (PCK_SZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (pop),
        .i_data  (w_pkt),
        .o_data  (data_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Watchdog counts cycles the head packet waits; it saturates at TIMEOUT.
    always_comb begin
        w_wd_nxt = r_wd;
        if (w_pop_ok || w_empty) begin
            w_wd_nxt = '0;
        end else if (r_wd != C_TIMEOUT) begin
            w_wd_nxt = r_wd + C_WD_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd          <= '0;
            tx_count      <= '0;
            drop_count    <= '0;
            stall_err     <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            r_wd <= w_wd_nxt;
            if (w_pop_ok)                      tx_count      <= tx_count + 16'd1;
            if (w_drop && drop_count != 8'hFF) drop_count    <= drop_count + 8'd1;
            if (w_wd_nxt == C_TIMEOUT)         stall_err     <= 1'b1;
            if (pop && w_empty)                underflow_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/router_term_source.md
Name: router_term_source

Overview:
- Terminal-side packet source for one router terminal. It is the transmitting end of the terminal input interface: it presents pndng/data_out, and the router consumes packets with pop.
- Buffers packet requests from a local generator in a first-word-fall-through FIFO and stamps header fields.
- Drops requests with an illegal destination.
- Flags a stalled router with a watchdog.
- One instance per terminal in the mesh bench/top. The per-terminal outputs aggregate into the router's data_out_i_in[], pndng_i_in[] and popin[] arrays.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- PCK_SZ, 40, packet width in bits.
- TERM_ID, 0, this terminal's index, 0..N_TERMS-1.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 128, maximum cycles pndng may stay high without a pop.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  generator offers a packet.
- req_ready  out  1  source can accept the packet this cycle.
- req_dst  in  6  destination terminal index.
- req_mode  in  1  routing mode bit.
- req_payload  in  PCK_SZ-15  payload.
- data_out  out  PCK_SZ  head-of-FIFO packet.
- pndng  out  1  FIFO not empty.
- pop  in  1  router consumes the head packet.
- tx_count  out  16  packets popped, wrapping counter.
- drop_count  out  8  requests rejected, saturating counter.
- stall_err  out  1  sticky: watchdog expired.
- underflow_err  out  1  sticky: pop seen while pndng was low.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, so pndng=0 and data_out=0.
  - tx_count=0, drop_count=0, stall_err=0, underflow_err=0.
  - Watchdog counter=0.
- Packet format, MSB first:
  - [PCK_SZ-1:PCK_SZ-8] nxt_jmp, stamped as 0.
  - [PCK_SZ-9:PCK_SZ-14] dst = req_dst.
  - [PCK_SZ-15] mode = req_mode.
  - [PCK_SZ-16:0] payload.
- req_ready = !full. It is combinational from the occupancy counter; pop does not make a full FIFO ready.
- Accept: req_valid && req_ready on a clock edge.
  - If req_dst >= N_TERMS or req_dst == TERM_ID, the request is dropped: no write, and drop_count increments, saturating at 255.
  - Otherwise the formed packet is written at the write pointer.
- Latency: a packet accepted at edge N is visible at edge N. pndng=1 and data_out are valid after edge N, i.e. in cycle N+1.
- data_out is driven from registered storage at the read pointer and is 0 when empty.
- pop while pndng=1 advances the read pointer and increments tx_count, which wraps at 2^16.
- pop while pndng=0 is ignored for the FIFO and sets underflow_err.
- Simultaneous push and pop with the FIFO non-empty: occupancy is unchanged and both pointers advance.
- Push into an empty FIFO in the same cycle as a pop: the pop is an underflow, since pndng was 0, and the push still completes.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits; full = (occ==DEPTH), empty = (occ==0).
- Watchdog:
  - Counter clears on any pop or when pndng=0.
  - Otherwise it increments while pndng=1.
  - When it reaches TIMEOUT, stall_err is set and stays set; the counter holds at TIMEOUT.
  - The 128-cycle progress bound is enforced here at the source side.
- Reset mid-operation discards all buffered packets immediately. No partial state survives.
- Sticky flags clear only on reset.

Decomposition:
- Shared package router_pkg holds:
  - N_TERMS = 2*ROWS + 2*COLUMS.
  - Field position constants NXT_MSB/NXT_LSB, DST_MSB/DST_LSB, MODE_BIT, PAYLOAD_MSB.
  - Function dst_of(), which returns the DST field.
  - Function pkt_form(dst, mode, payload).
- One sub-module, router_fwft_fifo. It owns storage, pointers, occupancy, full/empty and FWFT data_out.
- The source keeps the legality check, counters and watchdog.

Test Plan:
- Reset then idle 10 cycles:
  - pndng=0, data_out=0, req_ready=1, all counters and flags 0.
- TERM_ID=0, push dst=5, mode=1, payload=0x1ABCDE:
  - Next cycle pndng=1.
  - dst_of(data_out)=5, bit 25=1, nxt_jmp=0.
  - pop -> pndng=0, tx_count=1.
- Push 8 legal packets with no pops:
  - After the 8th, req_ready=0.
  - A 9th req_valid is not accepted and drop_count stays 0.
  - Then pop 8 times -> the packets leave in order, and tx_count=8.
- Push dst=0 (own ID) and dst=16 (N_TERMS=16):
  - Both dropped, drop_count=2, pndng stays 0.
- One packet held with no pop for 128 cycles:
  - stall_err rises on the 128th cycle of pndng=1 and stays high after a later pop.
- Pop while empty -> underflow_err=1.
- reset pulsed low with 3 packets queued -> pndng=0 immediately (asynchronous), and counters return to 0.
